bus_arbiter2x32: RTL and testbench

- Upstream stage for buffer_mux2x32. Accepts 32-bit words from two independent producers (A and B) over valid/ready handshakes and holds one word per source.
- Arbitrates between the sources and drives the mux data inputs and its complementary select pair (SEL_A / N_SEL_A).
- Presents a valid/ready handshake to the consumer, which samples the mux OUT.

---
 rtl/bus_arbiter2x32.sv | 131 +++++++++++++
 tb/tb_bus_arbiter2x32.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter2x32.sv
// Two-source arbiter feeding buffer_mux2x32: one holding register per source,
// round-robin or A-priority tie break, valid/ready handshake toward the consumer.
module bus_arbiter2x32 #(
  parameter int unsigned PRIORITY_A = 0
) (
  input  logic        CLK,
  input  logic        N_RST,
  input  logic [31:0] A_IN,
  input  logic        A_VALID,
  output logic        A_READY,
  input  logic [31:0] B_IN,
  input  logic        B_VALID,
  output logic        B_READY,
  output logic [31:0] A,
  output logic [31:0] B,
  output logic        SEL_A,
  output logic        N_SEL_A,
  output logic        DST_VALID,
  input  logic        DST_READY
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } state_t;

  state_t      state, state_nx;
  logic        full_a, full_b;
  logic        full_a_nx, full_b_nx;
  logic [31:0] a_q, b_q;
  logic        sel_a_q, sel_a_nx;
  logic        last_a, last_a_nx;   // 1: A was granted most recently
  logic        cap_a, cap_b;

  // Ready comes only from the registered full flags, never from inputs.
  assign A_READY   = !full_a;
  assign B_READY   = !full_b;
  assign cap_a     = A_VALID && !full_a;
  assign cap_b     = B_VALID && !full_b;

  assign A         = a_q;
  assign B         = b_q;
  assign SEL_A     = sel_a_q;
  assign N_SEL_A   = ~sel_a_q;
  assign DST_VALID = (state != IDLE);

  always_comb begin
    state_nx  = state;
    last_a_nx = last_a;
    full_a_nx = full_a | cap_a;
    full_b_nx = full_b | cap_b;
    sel_a_nx  = sel_a_q;

    unique case (state)
      IDLE: begin
        if (full_a && full_b) begin
          state_nx = ((PRIORITY_A != 0) || !last_a) ? GRANT_A : GRANT_B;
        end else if (full_a) begin
          state_nx = GRANT_A;
        end else if (full_b) begin
          state_nx = GRANT_B;
        end
      end
      // Hand-over looks at the other flag before this edge's capture, so a word
      // arriving together with the accept waits one cycle in IDLE.
      GRANT_A: begin
        if (DST_READY) begin
          full_a_nx = 1'b0;
          last_a_nx = 1'b1;
          state_nx  = full_b ? GRANT_B : IDLE;
        end
      end
      GRANT_B: begin
        if (DST_READY) begin
          full_b_nx = 1'b0;
          last_a_nx = 1'b0;
          state_nx  = full_a ? GRANT_A : IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase

    if (state_nx == GRANT_A) begin
      sel_a_nx = 1'b1;
    end else if (state_nx == GRANT_B) begin
      sel_a_nx = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge N_RST) begin
    if (!N_RST) begin
      state   <= IDLE;
      full_a  <= 1'b0;
      full_b  <= 1'b0;
      last_a  <= 1'b0;
      sel_a_q <= 1'b1;
    end else begin
      state   <= state_nx;
      full_a  <= full_a_nx;
      full_b  <= full_b_nx;
      last_a  <= last_a_nx;
      sel_a_q <= sel_a_nx;
    end
  end

  always_ff @(posedge CLK or negedge N_RST) begin
    if (!N_RST) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      if (cap_a) a_q <= A_IN;
      if (cap_b) b_q <= B_IN;
    end
  end

  a_sel_pair: assert property (@(posedge CLK) SEL_A ^ N_SEL_A);

  a_valid_full: assert property (@(posedge CLK) disable iff (!N_RST)
    DST_VALID |-> ((state == GRANT_A) ? full_a : full_b));

  a_stable_a: assert property (@(posedge CLK) disable iff (!N_RST)
    (state == GRANT_A && !DST_READY) |=> $stable(a_q));

  a_stable_b: assert property (@(posedge CLK) disable iff (!N_RST)
    (state == GRANT_B && !DST_READY) |=> $stable(b_q));

  a_no_ready_in_grant: assert property (@(posedge CLK) disable iff (!N_RST)
    !(state == GRANT_A && A_READY));

endmodule

// File: tb/tb_bus_arbiter2x32.sv
// Self-checking bench for bus_arbiter2x32: directed scenarios plus random traffic
// against a transaction-level reference model, for both tie-break settings.
module tb_bus_arbiter2x32;

  logic        clk = 1'b0;
  logic        n_rst = 1'b1;
  logic [31:0] a_in = '0;
  logic [31:0] b_in = '0;
  logic        a_valid = 1'b0;
  logic        b_valid = 1'b0;
  logic        dst_ready = 1'b0;

  logic [1:0]  dv, sel, nsel, ard, brd;
  logic [31:0] ao [2];
  logic [31:0] bo [2];

  int checks = 0;
  int failures = 0;

  localparam logic [68:0] RST_VEC = {5'b01011, 64'h0};

  always #5 clk = ~clk;

  bus_arbiter2x32 #(.PRIORITY_A(0)) dut_rr (
    .CLK(clk), .N_RST(n_rst),
    .A_IN(a_in), .A_VALID(a_valid), .A_READY(ard[0]),
    .B_IN(b_in), .B_VALID(b_valid), .B_READY(brd[0]),
    .A(ao[0]), .B(bo[0]), .SEL_A(sel[0]), .N_SEL_A(nsel[0]),
    .DST_VALID(dv[0]), .DST_READY(dst_ready)
  );

  bus_arbiter2x32 #(.PRIORITY_A(1)) dut_fp (
    .CLK(clk), .N_RST(n_rst),
    .A_IN(a_in), .A_VALID(a_valid), .A_READY(ard[1]),
    .B_IN(b_in), .B_VALID(b_valid), .B_READY(brd[1]),
    .A(ao[1]), .B(bo[1]), .SEL_A(sel[1]), .N_SEL_A(nsel[1]),
    .DST_VALID(dv[1]), .DST_READY(dst_ready)
  );

  // Reference model: grant is 0 (none), 1 (A) or 2 (B); last is 1 (A) or 2 (B).
  typedef struct {
    logic        fa;
    logic        fb;
    logic [31:0] a;
    logic [31:0] b;
    int          grant;
    logic        sel;
    int          last;
  } mdl_t;

  mdl_t mdl [2];

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.fa = 1'b0; m.fb = 1'b0; m.a = '0; m.b = '0;
    m.grant = 0; m.sel = 1'b1; m.last = 2;
    return m;
  endfunction

  function automatic mdl_t mdl_step(mdl_t m, int pa, logic av, logic [31:0] ai,
                                    logic bv, logic [31:0] bi, logic dr);
    mdl_t n = m;
    logic take_a = av && !m.fa;
    logic take_b = bv && !m.fb;
    if (m.grant == 0) begin
      if (m.fa && m.fb) n.grant = (pa == 1) ? 1 : 3 - m.last;
      else if (m.fa)    n.grant = 1;
      else if (m.fb)    n.grant = 2;
    end else if (dr) begin
      if (m.grant == 1) begin
        n.fa = 1'b0; n.last = 1; n.grant = m.fb ? 2 : 0;
      end else begin
        n.fb = 1'b0; n.last = 2; n.grant = m.fa ? 1 : 0;
      end
    end
    if (take_a) begin n.fa = 1'b1; n.a = ai; end
    if (take_b) begin n.fb = 1'b1; n.b = bi; end
    if (n.grant == 1)      n.sel = 1'b1;
    else if (n.grant == 2) n.sel = 1'b0;
    return n;
  endfunction

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      mdl[0] <= mdl_reset();
      mdl[1] <= mdl_reset();
    end else begin
      mdl[0] <= mdl_step(mdl[0], 0, a_valid, a_in, b_valid, b_in, dst_ready);
      mdl[1] <= mdl_step(mdl[1], 1, a_valid, a_in, b_valid, b_in, dst_ready);
    end
  end

  function automatic logic [68:0] exp_vec(mdl_t m);
    return {(m.grant != 0), m.sel, ~m.sel, ~m.fa, ~m.fb, m.a, m.b};
  endfunction

  function automatic logic [68:0] act_vec(int k);
    return {dv[k], sel[k], nsel[k], ard[k], brd[k], ao[k], bo[k]};
  endfunction

  function automatic logic [31:0] bus_word(int k);
    return sel[k] ? ao[k] : bo[k];
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    #2 n_rst = 1'b0;
    @(negedge clk);
    #2 n_rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #2 n_rst = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (act_vec(k) !== RST_VEC) begin
        failures++;
        $display("FAIL reset_async[%0d]: got %h expected %h", k, act_vec(k), RST_VEC);
      end
    end
    @(negedge clk);
    #2 n_rst = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (act_vec(k) !== RST_VEC) begin
        failures++;
        $display("FAIL reset_release[%0d]: got %h expected %h", k, act_vec(k), RST_VEC);
      end
    end
  endtask

  task automatic test_single_a();
    a_in = 32'hDEADBEEF;
    a_valid = 1'b1;
    tick();
    a_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({ard[k], dv[k]} !== 2'b00) begin
        failures++;
        $display("FAIL single_capture[%0d]: ready,valid got %b expected 00", k, {ard[k], dv[k]});
      end
    end
    tick();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({dv[k], sel[k], nsel[k], ao[k]} !== {3'b110, 32'hDEADBEEF}) begin
        failures++;
        $display("FAIL single_grant[%0d]: got %b%b%b %h expected 110 deadbeef",
                 k, dv[k], sel[k], nsel[k], ao[k]);
      end
    end
    dst_ready = 1'b1;
    tick();
    dst_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({dv[k], ard[k]} !== 2'b01) begin
        failures++;
        $display("FAIL single_accept[%0d]: valid,ready got %b expected 01", k, {dv[k], ard[k]});
      end
    end
  endtask

  task automatic test_tie();
    do_reset();
    for (int r = 0; r < 2; r++) begin
      logic [31:0] wa = 32'(1 + 2 * r);
      logic [31:0] wb = 32'(2 + 2 * r);
      a_in = wa; b_in = wb;
      a_valid = 1'b1; b_valid = 1'b1;
      tick();
      a_valid = 1'b0; b_valid = 1'b0;
      dst_ready = 1'b1;
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if ({dv[k], sel[k], bus_word(k)} !== {2'b11, wa}) begin
          failures++;
          $display("FAIL tie_first[%0d] round %0d: got %b%b %h expected 11 %h",
                   k, r, dv[k], sel[k], bus_word(k), wa);
        end
      end
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if ({dv[k], sel[k], bus_word(k)} !== {2'b10, wb}) begin
          failures++;
          $display("FAIL tie_second[%0d] round %0d: got %b%b %h expected 10 %h",
                   k, r, dv[k], sel[k], bus_word(k), wb);
        end
      end
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (dv[k] !== 1'b0) begin
          failures++;
          $display("FAIL tie_idle[%0d] round %0d: valid got %b expected 0", k, r, dv[k]);
        end
      end
      dst_ready = 1'b0;
    end
  endtask

  task automatic test_stall();
    a_in = 32'h77;
    a_valid = 1'b1;
    tick();
    a_valid = 1'b0;
    tick();
    b_in = 32'h55;
    b_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      b_valid = 1'b0;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if ({dv[k], sel[k], nsel[k], brd[k], ao[k], bo[k]} !== {4'b1100, 32'h77, 32'h55}) begin
          failures++;
          $display("FAIL stall_hold[%0d] cycle %0d: got %b%b%b%b %h %h expected 1100 77 55",
                   k, i, dv[k], sel[k], nsel[k], brd[k], ao[k], bo[k]);
        end
      end
    end
    dst_ready = 1'b1;
    tick();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({dv[k], sel[k], nsel[k], bus_word(k)} !== {3'b101, 32'h55}) begin
        failures++;
        $display("FAIL stall_handover[%0d]: got %b%b%b %h expected 101 55",
                 k, dv[k], sel[k], nsel[k], bus_word(k));
      end
    end
    tick();
    dst_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (dv[k] !== 1'b0) begin
        failures++;
        $display("FAIL stall_drain[%0d]: valid got %b expected 0", k, dv[k]);
      end
    end
  endtask

  task automatic test_fixed_priority();
    do_reset();
    a_valid = 1'b1; b_valid = 1'b1; dst_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i == 8) begin
        a_valid = 1'b0; b_valid = 1'b0;
      end
      a_in = $urandom; b_in = $urandom;
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (act_vec(k) !== exp_vec(mdl[k])) begin
          failures++;
          $display("FAIL priority_stream[%0d] cycle %0d: got %h expected %h",
                   k, i, act_vec(k), exp_vec(mdl[k]));
        end
      end
    end
    dst_ready = 1'b0;
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    b_in = 32'hB0B; b_valid = 1'b1;
    tick();
    b_valid = 1'b0;
    tick();
    a_in = 32'hA0A; a_valid = 1'b1;
    tick();
    a_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({dv[k], sel[k], ard[k]} !== 3'b100) begin
        failures++;
        $display("FAIL midrst_setup[%0d]: got %b expected 100", k, {dv[k], sel[k], ard[k]});
      end
    end
    #3 n_rst = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (act_vec(k) !== RST_VEC) begin
        failures++;
        $display("FAIL midrst_async[%0d]: got %h expected %h", k, act_vec(k), RST_VEC);
      end
    end
    @(negedge clk);
    #2 n_rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (act_vec(k) !== RST_VEC) begin
          failures++;
          $display("FAIL midrst_quiet[%0d] cycle %0d: got %h expected %h", k, i, act_vec(k), RST_VEC);
        end
      end
    end
    a_in = 32'h1234; a_valid = 1'b1;
    tick();
    a_valid = 1'b0;
    tick();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({dv[k], sel[k], ao[k]} !== {2'b11, 32'h1234}) begin
        failures++;
        $display("FAIL midrst_recover[%0d]: got %b%b %h expected 11 1234", k, dv[k], sel[k], ao[k]);
      end
    end
    dst_ready = 1'b1;
    tick();
    dst_ready = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      a_valid   = 1'($urandom_range(0, 1));
      b_valid   = 1'($urandom_range(0, 1));
      dst_ready = ($urandom_range(0, 9) < 7);
      a_in      = $urandom;
      b_in      = $urandom;
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (act_vec(k) !== exp_vec(mdl[k])) begin
          failures++;
          $display("FAIL random[%0d] cycle %0d: got %h expected %h",
                   k, i, act_vec(k), exp_vec(mdl[k]));
        end
      end
    end
    a_valid = 1'b0; b_valid = 1'b0; dst_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_single_a();
    test_tie();
    test_stall();
    test_fixed_priority();
    test_reset_mid_grant();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
